serial_transmitter_p: RTL and testbench
=======================================

# serial_transmitter_p

Parametrised serial transmitter, successor to the fixed 8-bit, one-clock-per-bit transmitter in the serial link path. It serialises one DATA_W-bit word per frame: start bit, data, optional parity, one or two stop bits. Bit period, bit order and parity are set by parameters. It sits between the packet/byte sequencer, which drives data_in and start, and the line driver on tx. Unlike the previous generation it adds a bit-period divider, parity, configurable stop bits, a completion pulse, and an asynchronous reset.

## Interface
- DATA_W, 8: data bits per frame, legal 5..16
- CLKS_PER_BIT, 1: clk cycles per line bit, ≥1; 1 gives the previous generation's bit rate
- PARITY, 0: 0 none, 1 even, 2 odd
- STOP_BITS, 1: 1 or 2
- MSB_FIRST, 0: 0 sends LSB first, 1 sends MSB first
- clk  in  1  system clock; all logic on the rising edge
- reset  in  1  asynchronous, active-high; clears all state
- data_in  in  DATA_W  word to send; sampled only on the accepting edge
- start  in  1  request; a rising edge (start=1, registered start_d=0) while ready=1 launches a frame
- tx  out  1  serial line; idles high
- ready  out  1  high only when state=IDLE
- done  out  1  one-cycle pulse when a frame completes

## Operation
- Reset values: tx=1, ready=1, done=0, state=IDLE, counters=0, shift register=0, start_d=1.
- start_d resets to 1, so a start held high through reset launches nothing. A rising edge is required after reset.
- States: IDLE → START → DATA → (PARITY if PARITY≠0) → STOP → IDLE.
- IDLE
  - tx=1, ready=1.
  - On an accepted edge: latch data_in into the shift register, tx←0, ready←0, go to START.
  - If MSB_FIRST=1, reverse the word on load.
- START: hold tx=0 for CLKS_PER_BIT cycles, then go to DATA. tx takes shift[0].
- DATA
  - Each bit lasts CLKS_PER_BIT cycles. At the end of each bit, shift right and increment bit_cnt.
  - After bit DATA_W−1, go to PARITY (tx←parity bit) or to STOP (tx←1).
- PARITY: even = XOR of the latched word; odd = its inverse. Lasts one bit period.
- STOP
  - tx=1 for STOP_BITS×CLKS_PER_BIT cycles, then go to IDLE.
  - On that transition: ready←1 and done←1 for exactly one cycle.
- Start edges while ready=0 are ignored and not queued. start_d keeps tracking start every cycle, so a level still high at frame end does not retrigger.
- Changes on data_in after acceptance do not affect the frame in flight.
- Reset mid-frame: tx=1 and ready=1 immediately (asynchronous), the frame is abandoned, done is not pulsed.
- Widths
  - bit_cnt is clog2(DATA_W) bits.
  - The divider is clog2(CLKS_PER_BIT) bits, with a minimum of 1. It wraps at CLKS_PER_BIT−1.
  - The stop counter is 1 bit.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- Accepting edge at clock k: tx=0 and ready=0 from k+1.
- Frame length F = (1 + DATA_W + (PARITY≠0) + STOP_BITS) × CLKS_PER_BIT cycles. tx carries the frame over cycles k+1 … k+F.
- done=1 and ready=1 in cycle k+F+1.
- Earliest next frame: a start edge sampled in cycle k+F+1 gives a new start bit at k+F+2, so the idle gap is exactly one cycle.
- Bit boundaries occur when the divider reaches CLKS_PER_BIT−1. With CLKS_PER_BIT=1 the divider is inert and every cycle is a boundary.

## Structure
- Shared package/include serial_pkg:
  - state encodings: IDLE, START, DATA, PARITY, STOP
  - parity mode constants: PAR_NONE, PAR_EVEN, PAR_ODD
- Sub-module serial_bit_timer, parametrised by CLKS_PER_BIT:
  - inputs: clk, reset, clear
  - output: tick, high in the last cycle of each bit period
  - clear is asserted on frame acceptance so the first bit period is exact.
- The state machine, shift register and parity register live in serial_transmitter_p.

## Test plan
- Defaults, data_in=8'hA5, one start edge → tx = 0,1,0,1,0,0,1,0,1,1 over 10 cycles; ready low for 10 cycles; done pulse at k+11.
- CLKS_PER_BIT=4, PARITY=1, data_in=8'h07 → 11 bits × 4 = 44 tx cycles; parity bit 1; start bit low for exactly 4 cycles.
- DATA_W=5, MSB_FIRST=1, STOP_BITS=2, PARITY=2, data_in=5'b10011 → tx = 0,1,0,0,1,1,0,1,1. Odd parity is 0 because the word has three ones.
- start held high for 50 cycles, plus a second start edge in the middle of a frame → exactly one frame, no retrigger; a new edge after done → second frame after a 1-cycle gap.
- reset asserted during data bit 3 (with CLKS_PER_BIT=4) → tx=1 and ready=1 in the same cycle, no done; a subsequent edge sends a complete correct frame.
- start already high when reset deasserts → no frame until start falls and rises again.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial transmitter family.
// Holds the FSM state encoding and the parity mode constants.
// No logic lives here; importers decide how the values are used.
package serial_pkg;

  // Frame phases, in line order.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // Parity modes selected by the PARITY parameter.
  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

endpackage

// File: rtl/serial_bit_timer.sv
// Bit-period divider: tick marks the last clk cycle of every line bit.
// Latency: tick is decoded from the divider register, no extra delay.
// No backpressure; clear restarts the period so the first bit is exact.
module serial_bit_timer #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  // With CLKS_PER_BIT=1 the counter is pinned at zero and every cycle ticks.
  localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [DIV_W-1:0] LAST = DIV_W'(CLKS_PER_BIT - 1);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;

  // Next divider value: wrap at the end of a period or on restart.
  always_comb begin
    div_d = div_q + DIV_W'(1);
    if (clear || (div_q == LAST)) begin
      div_d = '0;
    end
  end

  // Divider register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  assign tick = (div_q == LAST);

endmodule

// File: rtl/serial_transmitter_p.sv
// Parametrised UART-style transmitter: start, DATA_W data bits, optional parity, 1-2 stop bits.
// Latency: accepting edge at k -> start bit on tx from k+1; done/ready at k+F+1.
// Start edges while busy are dropped (not queued); ready is high only in IDLE.
module serial_transmitter_p
  import serial_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int MSB_FIRST    = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              start,
  output logic              tx,
  output logic              ready,
  output logic              done
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic              stop_q, stop_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  // Previous-cycle copy of start; resets high so a level held through reset is not an edge.
  logic              start_d_q;

  logic              accept;
  logic              tick;
  logic              stop_last;
  logic [DATA_W-1:0] load_word;

  assign accept    = (state_q == ST_IDLE) && start && !start_d_q;
  assign stop_last = (STOP_BITS == 1) || stop_q;

  serial_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .clear(accept),
    .tick (tick)
  );

  // Word as it enters the shift register; MSB-first frames are bit-reversed so the FSM always shifts right.
  always_comb begin
    load_word = data_in;
    if (MSB_FIRST != 0) begin
      for (int i = 0; i < DATA_W; i++) begin
        load_word[i] = data_in[DATA_W-1-i];
      end
    end
  end

  // Next-state and registered-output logic; tx_d is the line value for the next cycle.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    stop_d    = stop_q;
    par_d     = par_q;
    tx_d      = tx_q;
    ready_d   = ready_q;
    done_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        tx_d    = 1'b1;
        ready_d = 1'b1;
        if (accept) begin
          shift_d   = load_word;
          par_d     = (^data_in) ^ (PARITY == PAR_ODD);
          bit_cnt_d = '0;
          stop_d    = 1'b0;
          tx_d      = 1'b0;
          ready_d   = 1'b0;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          tx_d    = shift_q[0];
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            if (PARITY != PAR_NONE) begin
              tx_d    = par_q;
              state_d = ST_PARITY;
            end else begin
              tx_d    = 1'b1;
              stop_d  = 1'b0;
              state_d = ST_STOP;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            tx_d      = shift_q[1];
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          tx_d    = 1'b1;
          stop_d  = 1'b0;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (tick) begin
          if (stop_last) begin
            ready_d = 1'b1;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and output registers; reset abandons any frame in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      stop_q    <= 1'b0;
      par_q     <= 1'b0;
      tx_q      <= 1'b1;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      start_d_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      stop_q    <= stop_d;
      par_q     <= par_d;
      tx_q      <= tx_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      start_d_q <= start;
    end
  end

  assign tx    = tx_q;
  assign ready = ready_q;
  assign done  = done_q;

endmodule

// File: tb/tb_serial_transmitter_p.sv
// Bench for serial_transmitter_p: three configurations run side by side.
// Drivers push expected frames (bits + first-cycle) to per-instance queues;
// a negedge monitor pops them when a start bit appears and checks every cycle.
module tb_serial_transmitter_p;

  typedef struct {
    logic [31:0] b;
    int          n;
    int          t0;
  } frame_t;

  // Instance 0: defaults. 1: CLKS_PER_BIT=4, even parity. 2: 5 bits, MSB first, odd parity, 2 stops.
  function automatic int p_dw(input int d);  return (d == 2) ? 5 : 8; endfunction
  function automatic int p_cpb(input int d); return (d == 1) ? 4 : 1; endfunction
  function automatic int p_par(input int d); return d;                endfunction
  function automatic int p_stp(input int d); return (d == 2) ? 2 : 1; endfunction
  function automatic int p_msb(input int d); return (d == 2) ? 1 : 0; endfunction

  logic       clk;
  logic [2:0] rst_v;
  logic [2:0] start_v;
  logic [7:0] din0, din1;
  logic [4:0] din2;
  wire  [2:0] tx_v, ready_v, done_v;
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;

  frame_t q0[$];
  frame_t q1[$];
  frame_t q2[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_transmitter_p u_dut0 (
    .clk(clk), .reset(rst_v[0]), .data_in(din0), .start(start_v[0]),
    .tx(tx_v[0]), .ready(ready_v[0]), .done(done_v[0])
  );

  serial_transmitter_p #(
    .DATA_W(8), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1), .MSB_FIRST(0)
  ) u_dut1 (
    .clk(clk), .reset(rst_v[1]), .data_in(din1), .start(start_v[1]),
    .tx(tx_v[1]), .ready(ready_v[1]), .done(done_v[1])
  );

  serial_transmitter_p #(
    .DATA_W(5), .CLKS_PER_BIT(1), .PARITY(2), .STOP_BITS(2), .MSB_FIRST(1)
  ) u_dut2 (
    .clk(clk), .reset(rst_v[2]), .data_in(din2), .start(start_v[2]),
    .tx(tx_v[2]), .ready(ready_v[2]), .done(done_v[2])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Reference frame built straight from the line format.
  function automatic frame_t mk(input int d, input logic [15:0] w, input int t0);
    frame_t f;
    int     n;
    logic   p;
    f.b = '0;
    n = 1;
    p = 1'b0;
    for (int i = 0; i < p_dw(d); i++) begin
      f.b[n] = w[(p_msb(d) != 0) ? (p_dw(d) - 1 - i) : i];
      p = p ^ w[i];
      n++;
    end
    if (p_par(d) != 0) begin
      f.b[n] = (p_par(d) == 2) ? ~p : p;
      n++;
    end
    for (int s = 0; s < p_stp(d); s++) begin
      f.b[n] = 1'b1;
      n++;
    end
    f.n  = n;
    f.t0 = t0;
    return f;
  endfunction

  function automatic void push_exp(input int d, input frame_t f);
    case (d)
      0:       q0.push_back(f);
      1:       q1.push_back(f);
      default: q2.push_back(f);
    endcase
  endfunction

  function automatic int q_size(input int d);
    case (d)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic frame_t pop_exp(input int d);
    case (d)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  // Call at a negedge with start_v[d] low in the previous cycle; raises start and records the expected frame.
  task automatic send(input int d, input logic [15:0] w);
    int k;
    k = 0;
    while (!ready_v[d] && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (!ready_v[d]) chk($sformatf("ready_wait%0d", d), {31'd0, ready_v[d]}, 32'd1);
    case (d)
      0:       din0 = w[7:0];
      1:       din1 = w[7:0];
      default: din2 = w[4:0];
    endcase
    start_v[d] = 1'b1;
    push_exp(d, mk(d, w, cyc + 1));
  endtask

  // Returns at the negedge where done is seen, or flags a timeout.
  task automatic wait_done(input int d);
    int k;
    k = 0;
    @(negedge clk);
    while (!done_v[d] && k < 2000) begin
      @(negedge clk);
      k++;
    end
    if (!done_v[d]) chk($sformatf("done_wait%0d", d), 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  bit     act[3];
  bit     exp_done[3];
  int     mcnt[3];
  frame_t cur[3];

  // Monitor: per-cycle tx/ready/done checks against the popped expected frame.
  initial begin
    for (int d = 0; d < 3; d++) begin
      act[d] = 1'b0;
      exp_done[d] = 1'b0;
      mcnt[d] = 0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (rst_v[d]) begin
          act[d] = 1'b0;
          exp_done[d] = 1'b0;
        end else if (exp_done[d]) begin
          chk($sformatf("done_pulse%0d", d), {31'd0, done_v[d]}, 32'd1);
          chk($sformatf("ready_after%0d", d), {31'd0, ready_v[d]}, 32'd1);
          exp_done[d] = 1'b0;
        end else if (act[d]) begin
          chk($sformatf("tx_bit%0d", d), {31'd0, tx_v[d]}, {31'd0, cur[d].b[mcnt[d] / p_cpb(d)]});
          chk($sformatf("ready_busy%0d", d), {31'd0, ready_v[d]}, 32'd0);
          chk($sformatf("done_busy%0d", d), {31'd0, done_v[d]}, 32'd0);
          mcnt[d]++;
          if (mcnt[d] == cur[d].n * p_cpb(d)) begin
            act[d] = 1'b0;
            exp_done[d] = 1'b1;
          end
        end else begin
          chk($sformatf("done_idle%0d", d), {31'd0, done_v[d]}, 32'd0);
          if (tx_v[d] == 1'b0) begin
            if (q_size(d) == 0) begin
              chk($sformatf("unexpected_frame%0d", d), 32'd1, 32'd0);
            end else begin
              cur[d] = pop_exp(d);
              chk($sformatf("latency%0d", d), cyc, cur[d].t0);
              chk($sformatf("ready_busy%0d", d), {31'd0, ready_v[d]}, 32'd0);
              act[d] = 1'b1;
              mcnt[d] = 1;
            end
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    rst_v   = 3'b111;
    start_v = 3'b000;
    din0 = '0;
    din1 = '0;
    din2 = '0;
    idle(3);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_tx%0d", d), {31'd0, tx_v[d]}, 32'd1);
      chk($sformatf("rst_ready%0d", d), {31'd0, ready_v[d]}, 32'd1);
      chk($sformatf("rst_done%0d", d), {31'd0, done_v[d]}, 32'd0);
    end
    rst_v = 3'b000;
    idle(1);

    // 0xA5 on the default configuration, then a back-to-back frame launched in the done cycle.
    send(0, 16'h00A5);
    idle(1); start_v[0] = 1'b0;
    wait_done(0);
    send(0, 16'h005C);
    idle(1); start_v[0] = 1'b0;
    wait_done(0);

    // Long start level with an extra edge mid-frame: exactly one frame, then a fresh edge.
    idle(2);
    send(0, 16'h003C);
    idle(3); start_v[0] = 1'b0;
    idle(1); start_v[0] = 1'b1;
    idle(50); start_v[0] = 1'b0;
    idle(2);
    send(0, 16'h0081);
    idle(1); start_v[0] = 1'b0;
    wait_done(0);

    // Divided bit period with even parity.
    idle(2);
    send(1, 16'h0007);
    idle(1); start_v[1] = 1'b0;
    wait_done(1);

    // MSB-first 5-bit word, odd parity, two stop bits.
    send(2, 16'h0013);
    idle(1); start_v[2] = 1'b0;
    wait_done(2);

    // A few random words on each configuration.
    for (int i = 0; i < 4; i++) begin
      for (int d = 0; d < 3; d++) begin
        send(d, 16'($urandom));
        idle(1); start_v[d] = 1'b0;
        wait_done(d);
      end
    end

    // Reset during data bit 3 (a 0 bit of 0xC3): line and ready recover at once, no done.
    idle(2);
    send(1, 16'h00C3);
    t0 = cyc + 1;
    idle(1); start_v[1] = 1'b0;
    while (cyc < t0 + 17) @(negedge clk);
    chk("pre_rst_tx", {31'd0, tx_v[1]}, 32'd0);
    #2;
    rst_v[1] = 1'b1;
    #1;
    chk("mid_rst_tx", {31'd0, tx_v[1]}, 32'd1);
    chk("mid_rst_ready", {31'd0, ready_v[1]}, 32'd1);
    chk("mid_rst_done", {31'd0, done_v[1]}, 32'd0);
    idle(2);
    rst_v[1] = 1'b0;
    idle(2);
    chk("post_rst_done", {31'd0, done_v[1]}, 32'd0);
    send(1, 16'h005A);
    idle(1); start_v[1] = 1'b0;
    wait_done(1);

    // Start held high across reset release must not launch a frame.
    idle(2);
    rst_v[2]   = 1'b1;
    start_v[2] = 1'b1;
    idle(3);
    rst_v[2] = 1'b0;
    idle(20);
    chk("held_start_ready", {31'd0, ready_v[2]}, 32'd1);
    chk("held_start_tx", {31'd0, tx_v[2]}, 32'd1);
    start_v[2] = 1'b0;
    idle(1);
    send(2, 16'h000B);
    idle(1); start_v[2] = 1'b0;
    wait_done(2);

    idle(4);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("queue_empty%0d", d), q_size(d), 32'd0);
      chk($sformatf("monitor_idle%0d", d), {31'd0, act[d]}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
